// File: rtl/xil_prim_pkg.sv
// Shared definitions for the primitive behavioural models: FSM state
// encoding and a width helper usable in constant expressions.
package xil_prim_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  // Bits needed to index 0..value-1; never returns less than 1.
  function automatic int clog2(input int value);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/oserdes_sdr.sv
// Parallel-to-serial output serializer: takes a word on a valid/ready
// handshake and shifts it out one bit per enabled clock on OQ.
module oserdes_sdr
  import xil_prim_pkg::*;
#(
  parameter int   DATA_WIDTH = 8,
  parameter logic INIT       = 1'b0,
  parameter int   LSB_FIRST  = 1
) (
  input  logic                  C,
  input  logic                  CLR,
  input  logic                  CE,
  input  logic [DATA_WIDTH-1:0] D,
  input  logic                  DV,
  output logic                  RDY,
  output logic                  OQ,
  output logic                  TQ,
  output logic                  LAST
);

  localparam int CNT_W = clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

  // Handshake: a word moves on a rising C when CE & DV & RDY. RDY depends
  // only on state (and CLR), never on DV, so it may be used to form DV.
  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic                  oq_q, oq_d;
  logic                  tq_q, tq_d;

  logic                  last_w;
  logic                  can_take;
  logic                  load_bit, next_bit;
  logic [DATA_WIDTH-1:0] load_rest, next_rest;

  assign last_w   = (state_q == ST_SHIFT) && (cnt_q == CNT_LAST);
  assign can_take = (state_q == ST_IDLE) || last_w;

  assign RDY  = !CLR && can_take;
  assign LAST = last_w;
  assign OQ   = oq_q;
  assign TQ   = tq_q;

  // The first bit goes straight to OQ on load; the shift register keeps
  // the rest, aligned so the next bit is always at the output end.
  always_comb begin
    if (LSB_FIRST != 0) begin
      load_bit  = D[0];
      load_rest = D >> 1;
      next_bit  = shreg_q[0];
      next_rest = shreg_q >> 1;
    end else begin
      load_bit  = D[DATA_WIDTH-1];
      load_rest = D << 1;
      next_bit  = shreg_q[DATA_WIDTH-1];
      next_rest = shreg_q << 1;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    oq_d    = oq_q;
    tq_d    = tq_q;
    if (CE) begin
      if (can_take && DV) begin
        state_d = ST_SHIFT;
        cnt_d   = '0;
        shreg_d = load_rest;
        oq_d    = load_bit;
        tq_d    = 1'b0;
      end else if (state_q == ST_SHIFT) begin
        if (last_w) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          shreg_d = '0;
          oq_d    = INIT;
          tq_d    = 1'b1;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
          shreg_d = next_rest;
          oq_d    = next_bit;
        end
      end
    end
  end

  always_ff @(posedge C or posedge CLR) begin
    if (CLR) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      shreg_q <= '0;
      oq_q    <= INIT;
      tq_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      oq_q    <= oq_d;
      tq_q    <= tq_d;
    end
  end

endmodule
